// File: rtl/chrono_button_controller_pkg.sv
// Shared constants, FSM encoding and transition function for the chrono button controller.
package chrono_pkg;

  localparam int DEBOUNCE_TICKS_DEF = 5;
  // Debounce counter width; covers DEBOUNCE_TICKS up to 255.
  localparam int CNT_W   = 8;
  localparam int NUM_BTN = 3;

  // Button slots in the debouncer array.
  localparam int BTN_SS  = 0;  // BTN_SOUTH, start/stop
  localparam int BTN_LAP = 1;  // BTN_EAST, lap
  localparam int BTN_RST = 2;  // BTN_NORTH, reset

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_LAP_RUN  = 2'd2,
    ST_LAP_STOP = 2'd3
  } state_e;

  // Priority reset > start/stop > lap; losing events are simply dropped.
  function automatic state_e next_state(state_e cur, logic ev_rst, logic ev_ss, logic ev_lap);
    state_e nxt;
    nxt = cur;
    if (ev_rst) begin
      nxt = ST_STOPPED;
    end else if (ev_ss) begin
      case (cur)
        ST_STOPPED:  nxt = ST_RUNNING;
        ST_RUNNING:  nxt = ST_STOPPED;
        ST_LAP_RUN:  nxt = ST_LAP_STOP;
        ST_LAP_STOP: nxt = ST_LAP_RUN;
        default:     nxt = ST_STOPPED;
      endcase
    end else if (ev_lap) begin
      case (cur)
        ST_RUNNING:  nxt = ST_LAP_RUN;
        ST_LAP_RUN:  nxt = ST_RUNNING;
        ST_LAP_STOP: nxt = ST_STOPPED;
        default:     nxt = cur;  // lap ignored while stopped
      endcase
    end
    return nxt;
  endfunction

  function automatic logic is_paused(state_e s);
    return (s == ST_STOPPED) || (s == ST_LAP_STOP);
  endfunction

  function automatic logic is_frozen(state_e s);
    return (s == ST_LAP_RUN) || (s == ST_LAP_STOP);
  endfunction

endpackage

// File: rtl/chrono_button_controller_if.sv
// Button/tick inputs and control outputs of the chrono button controller.
interface chrono_button_controller_if;
  logic       tick_100Hz;
  logic       BTN_SOUTH;
  logic       BTN_EAST;
  logic       BTN_NORTH;
  logic       pause;
  logic       counter_reset;
  logic       lap_freeze;
  logic       lap_capture;
  logic [1:0] state;

  // Board / stimulus side.
  modport master (
    output tick_100Hz, BTN_SOUTH, BTN_EAST, BTN_NORTH,
    input  pause, counter_reset, lap_freeze, lap_capture, state
  );

  // Controller side.
  modport slave (
    input  tick_100Hz, BTN_SOUTH, BTN_EAST, BTN_NORTH,
    output pause, counter_reset, lap_freeze, lap_capture, state
  );
endinterface

// File: rtl/chrono_button_controller_debouncer.sv
// One button: 2-flop synchronizer, tick-paced debounce counter, press pulse.
module button_debouncer
  import chrono_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_rise_i,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_TICKS);

  logic             sync1_q, sync2_q;
  logic             acc_q, acc_d;
  logic             acc_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count ticks while the synchronized level disagrees with the accepted one;
  // toggle on the last tick so the counter never goes past LIMIT.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (tick_rise_i) begin
      if (cnt_q >= LIMIT - CNT_W'(1)) begin
        acc_d = ~acc_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, accepted level and rising-edge pulse (one cycle after acceptance).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      acc_q     <= 1'b0;
      acc_dly_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
      cnt_q     <= cnt_d;
      press_q   <= acc_q & ~acc_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/chrono_button_controller.sv
// Stopwatch control: three debounced buttons drive a 4-state run/lap FSM.
module chrono_button_controller
  import chrono_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic                          CLK_50M,
  input  logic                          reset_n,
  chrono_button_controller_if.slave     bus
);

  logic               tick_q;
  logic               tick_rise;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  state_e state_q;
  logic   pause_q, lap_freeze_q, counter_reset_q, lap_capture_q;

  // Rising-edge detector on the 100 Hz tick, shared by all buttons.
  always_ff @(posedge CLK_50M) begin
    if (!reset_n) tick_q <= 1'b0;
    else          tick_q <= bus.tick_100Hz;
  end

  assign tick_rise = bus.tick_100Hz & ~tick_q;

  assign btn_raw[BTN_SS]  = bus.BTN_SOUTH;
  assign btn_raw[BTN_LAP] = bus.BTN_EAST;
  assign btn_raw[BTN_RST] = bus.BTN_NORTH;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_db (
      .clk_i       (CLK_50M),
      .rst_ni      (reset_n),
      .tick_rise_i (tick_rise),
      .btn_i       (btn_raw[i]),
      .press_o     (press[i])
    );
  end

  // FSM with registered outputs derived from the next state; pulses follow the winning event.
  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      state_q         <= ST_STOPPED;
      pause_q         <= 1'b1;
      lap_freeze_q    <= 1'b0;
      counter_reset_q <= 1'b0;
      lap_capture_q   <= 1'b0;
    end else begin
      state_q         <= next_state(state_q, press[BTN_RST], press[BTN_SS], press[BTN_LAP]);
      pause_q         <= is_paused(next_state(state_q, press[BTN_RST], press[BTN_SS], press[BTN_LAP]));
      lap_freeze_q    <= is_frozen(next_state(state_q, press[BTN_RST], press[BTN_SS], press[BTN_LAP]));
      counter_reset_q <= press[BTN_RST];
      lap_capture_q   <= ~press[BTN_RST] & ~press[BTN_SS] & press[BTN_LAP] &
                         (state_q == ST_RUNNING);
    end
  end

  assign bus.state         = state_q;
  assign bus.pause         = pause_q;
  assign bus.lap_freeze    = lap_freeze_q;
  assign bus.counter_reset = counter_reset_q;
  assign bus.lap_capture   = lap_capture_q;

endmodule

// File: tb/tb_chrono_button_controller.sv
// Bench for chrono_button_controller with DEBOUNCE_TICKS=3 and a 20-cycle tick.
module tb_chrono_button_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tcnt = 0;
  int   n_cr = 0, n_lc = 0;
  int   ntests = 0, nfail = 0;

  chrono_button_controller_if bus();

  chrono_button_controller #(.DEBOUNCE_TICKS(3)) dut (
    .CLK_50M (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // 20-cycle tick, 10 high / 10 low; the posedge after tcnt wraps to 0 sees the rise.
  always @(negedge clk) begin
    tcnt = (tcnt == 19) ? 0 : tcnt + 1;
    bus.tick_100Hz = (tcnt < 10);
  end

  // Count high cycles of each pulse output.
  always @(posedge clk) begin
    if (bus.counter_reset === 1'b1) n_cr++;
    if (bus.lap_capture === 1'b1)   n_lc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached, required end of test");
    $fatal(1);
  end

  // mask bits: [2]=NORTH, [1]=EAST, [0]=SOUTH
  typedef struct {
    logic [2:0] btn;
    int         st;
    int         pause;
    int         frz;
    int         nrst;
    int         ncap;
  } vec_t;

  vec_t vec_tbl[15];
  vec_t exp_q[$];

  task automatic chk(string nm, int act, int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_tick_edge();
    do @(posedge clk); while (tcnt != 0);
  endtask

  task automatic set_btn(logic [2:0] m);
    bus.BTN_NORTH = m[2];
    bus.BTN_EAST  = m[1];
    bus.BTN_SOUTH = m[0];
  endtask

  task automatic press(logic [2:0] m);
    @(negedge clk); set_btn(m);
    repeat (5) wait_tick_edge();
    @(negedge clk); set_btn(3'b000);
    repeat (5) wait_tick_edge();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v, e;
    int   b_cr, b_lc;

    vec_tbl[0]  = '{3'b010, 2, 0, 1, 0, 1};  // lap from RUNNING: capture
    vec_tbl[1]  = '{3'b001, 3, 1, 1, 0, 0};  // start/stop -> LAP_STOP
    vec_tbl[2]  = '{3'b010, 0, 1, 0, 0, 0};  // lap -> STOPPED
    vec_tbl[3]  = '{3'b010, 0, 1, 0, 0, 0};  // lap ignored in STOPPED
    vec_tbl[4]  = '{3'b001, 1, 0, 0, 0, 0};
    vec_tbl[5]  = '{3'b010, 2, 0, 1, 0, 1};
    vec_tbl[6]  = '{3'b010, 1, 0, 0, 0, 0};  // LAP_RUN -> RUNNING
    vec_tbl[7]  = '{3'b101, 0, 1, 0, 1, 0};  // north+south: reset wins
    vec_tbl[8]  = '{3'b001, 1, 0, 0, 0, 0};
    vec_tbl[9]  = '{3'b011, 0, 1, 0, 0, 0};  // east+south: start/stop wins, lap dropped
    vec_tbl[10] = '{3'b001, 1, 0, 0, 0, 0};
    vec_tbl[11] = '{3'b010, 2, 0, 1, 0, 1};
    vec_tbl[12] = '{3'b001, 3, 1, 1, 0, 0};
    vec_tbl[13] = '{3'b100, 0, 1, 0, 1, 0};  // reset from LAP_STOP
    vec_tbl[14] = '{3'b100, 0, 1, 0, 1, 0};  // reset from STOPPED still pulses

    set_btn(3'b000);
    reset_n = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst state", int'(bus.state), 0);
    chk("rst pause", int'(bus.pause), 1);
    chk("rst lap_freeze", int'(bus.lap_freeze), 0);
    chk("rst counter_reset", int'(bus.counter_reset), 0);
    chk("rst lap_capture", int'(bus.lap_capture), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post-rst state", int'(bus.state), 0);
    chk("post-rst pause", int'(bus.pause), 1);

    // Bounce: toggle every tick for 6 ticks, then stay low
    wait_tick_edge();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) bus.BTN_SOUTH = (k % 2 == 0);
      wait_tick_edge();
    end
    repeat (5) wait_tick_edge();
    #1;
    chk("bounce state", int'(bus.state), 0);
    chk("bounce pause", int'(bus.pause), 1);

    // Clean press: outputs move exactly 2 cycles after the third stable tick edge
    wait_tick_edge();
    @(negedge clk) bus.BTN_SOUTH = 1'b1;
    repeat (3) wait_tick_edge();
    @(posedge clk); #1;
    chk("clean pre state", int'(bus.state), 0);
    chk("clean pre pause", int'(bus.pause), 1);
    @(posedge clk); #1;
    chk("clean state", int'(bus.state), 1);
    chk("clean pause", int'(bus.pause), 0);
    repeat (7) wait_tick_edge();
    @(negedge clk) bus.BTN_SOUTH = 1'b0;
    repeat (5) wait_tick_edge();
    #1;
    chk("clean once state", int'(bus.state), 1);
    chk("clean once pause", int'(bus.pause), 0);

    // Table-driven button sequences through the scoreboard
    for (int i = 0; i < 15; i++) begin
      v = vec_tbl[i];
      exp_q.push_back(v);
      b_cr = n_cr;
      b_lc = n_lc;
      press(v.btn);
      e = exp_q.pop_front();
      chk($sformatf("row%0d state", i), int'(bus.state), e.st);
      chk($sformatf("row%0d pause", i), int'(bus.pause), e.pause);
      chk($sformatf("row%0d lap_freeze", i), int'(bus.lap_freeze), e.frz);
      chk($sformatf("row%0d counter_reset pulses", i), n_cr - b_cr, e.nrst);
      chk($sformatf("row%0d lap_capture pulses", i), n_lc - b_lc, e.ncap);
    end

    // Reset mid-debounce with BTN_EAST held
    press(3'b001);
    chk("pre-034 state", int'(bus.state), 1);
    wait_tick_edge();
    @(negedge clk) bus.BTN_EAST = 1'b1;
    repeat (2) wait_tick_edge();
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    #1;
    b_lc = n_lc;
    chk("midrst state", int'(bus.state), 0);
    chk("midrst pause", int'(bus.pause), 1);
    chk("midrst lap_freeze", int'(bus.lap_freeze), 0);
    for (int k = 0; k < 5; k++) begin
      wait_tick_edge();
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("midrst t%0d state", k), int'(bus.state), 0);
      chk($sformatf("midrst t%0d pause", k), int'(bus.pause), 1);
      chk($sformatf("midrst t%0d lap_freeze", k), int'(bus.lap_freeze), 0);
    end
    chk("midrst lap_capture pulses", n_lc - b_lc, 0);
    @(negedge clk) bus.BTN_EAST = 1'b0;
    repeat (5) wait_tick_edge();

    // Pending north event cancelled by reset
    wait_tick_edge();
    @(negedge clk) bus.BTN_NORTH = 1'b1;
    repeat (2) wait_tick_edge();
    @(negedge clk) begin reset_n = 1'b0; bus.BTN_NORTH = 1'b0; end
    @(negedge clk) reset_n = 1'b1;
    b_cr = n_cr;
    repeat (6) wait_tick_edge();
    #1;
    chk("cancel counter_reset pulses", n_cr - b_cr, 0);

    // BTN_NORTH held across reset release: one pulse three ticks later
    @(negedge clk) begin bus.BTN_NORTH = 1'b1; reset_n = 1'b0; end
    repeat (3) @(negedge clk);
    wait_tick_edge();
    @(negedge clk) reset_n = 1'b1;
    b_cr = n_cr;
    repeat (3) wait_tick_edge();
    @(posedge clk); #1;
    chk("held pre counter_reset", int'(bus.counter_reset), 0);
    @(posedge clk); #1;
    chk("held counter_reset", int'(bus.counter_reset), 1);
    @(posedge clk); #1;
    chk("held counter_reset end", int'(bus.counter_reset), 0);
    repeat (4) wait_tick_edge();
    chk("held counter_reset pulses", n_cr - b_cr, 1);
    @(negedge clk) bus.BTN_NORTH = 1'b0;
    repeat (5) wait_tick_edge();
    #1;
    chk("held final state", int'(bus.state), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
